// File: rtl/mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_arbiter
// Brief    : Round-robin arbiter sharing one combinational WxW multiplier
//            among NREQ requesters, with a single id-tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================
module mult_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic [2*W-1:0]      mul_c,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_c,
    input  logic                rsp_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_any;

    // Scan from the highest offset down so the nearest valid index at or
    // after the pointer is the last one written and therefore wins.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any  = 1'b1;
                w_gidx = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_ptr_nxt = IDW'((int'(w_gidx) + 1) % NREQ);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready   = NREQ'(1) << w_gidx;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        mul_a  <= req_a[int'(w_gidx) * W +: W];
                        mul_b  <= req_b[int'(w_gidx) * W +: W];
                        rsp_id <= w_gidx;
                        r_ptr  <= w_ptr_nxt;
                    end
                end
                S_CALC: begin
                    rsp_c     <= mul_c;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_rr_arbiter
// Brief    : Self-checking bench: directed vector table, reset corner case,
//            then random traffic against a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic [2*W-1:0]      mul_c;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_c;
    logic                rsp_ready;

    int n_checks;
    int n_errors;
    int m_ptr;

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        int                hold;
        int                id;
        int                c;
    } vec_t;

    vec_t tbl[11];

    // The shared multiplier the parent would normally provide.
    assign mul_c = mul_a * mul_b;

    mult_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered mid-cycle in IDLE with inputs driven; runs one full transaction.
    task automatic do_txn(input int eg, input int ec, input int hold);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(1 << eg));
        ea = req_a[eg*W +: W];
        eb = req_b[eg*W +: W];
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid[eg] = 1'b0;
        chk("calc_mul_a", 32'(mul_a), 32'(ea));
        chk("calc_mul_b", 32'(mul_b), 32'(eb));
        chk("calc_req_ready", 32'(req_ready), 32'd0);
        chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(eg));
        chk("rsp_c", 32'(rsp_c), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_c", 32'(rsp_c), 32'(ec));
            chk("hold_rsp_id", 32'(rsp_id), 32'(eg));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    // Round-robin reference: nearest valid index at or after the pointer.
    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int g;
        n_checks  = 0;
        n_errors  = 0;
        m_ptr     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        tbl[0]  = '{4'hF, 32'h04030201, 32'h0A0A0A0A, 0, 0, 10};
        tbl[1]  = '{4'hF, 32'h04030201, 32'h0A0A0A0A, 0, 1, 20};
        tbl[2]  = '{4'hF, 32'h04030201, 32'h0A0A0A0A, 0, 2, 30};
        tbl[3]  = '{4'hF, 32'h04030201, 32'h0A0A0A0A, 0, 3, 40};
        tbl[4]  = '{4'hF, 32'h04030201, 32'h0A0A0A0A, 0, 0, 10};
        tbl[5]  = '{4'h1, 32'h00000003, 32'h00000005, 0, 0, 15};
        tbl[6]  = '{4'h9, 32'hFF000011, 32'hFF000022, 5, 3, 16'hFE01};
        tbl[7]  = '{4'hA, 32'h0000FF00, 32'h00000200, 0, 1, 510};
        tbl[8]  = '{4'h8, 32'h00000000, 32'hC8000000, 0, 3, 0};
        tbl[9]  = '{4'h4, 32'h000A0000, 32'h00020000, 0, 2, 20};
        tbl[10] = '{4'h3, 32'h00000507, 32'h00000609, 1, 0, 63};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_c", 32'(rsp_c), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_mul_a", 32'(mul_a), 32'd0);
        @(posedge clk); #1;
        chk("idle_no_grant", 32'(req_ready), 32'd0);

        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            do_txn(tbl[i].id, tbl[i].c, tbl[i].hold);
        end
        // Table ends with a grant to 0, so the pointer now sits at 1.

        // Reset while the multiplier result is being captured.
        req_valid = 4'b0100;
        req_a     = 32'h00050000;
        req_b     = 32'h00060000;
        #1;
        chk("pre_reset_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midop_rsp_c", 32'(rsp_c), 32'd0);
        chk("midop_mul_a", 32'(mul_a), 32'd0);
        @(posedge clk); #1;
        chk("midop_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1010;
        req_a     = 32'h0B000C00;
        req_b     = 32'h02000300;
        do_txn(1, 36, 0);
        m_ptr = 2;

        // Random traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic [NREQ-1:0] v;
            int hold;
            v     = NREQ'($urandom_range(0, 15));
            hold  = int'($urandom_range(0, 2));
            req_a = $urandom;
            req_b = $urandom;
            req_valid = v;
            g = model_grant(v, m_ptr);
            if (g < 0) begin
                #1;
                chk("rand_idle_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
                chk("rand_idle_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                do_txn(g, int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]), hold);
                m_ptr = (g + 1) % NREQ;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
